// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART TX arbiter: FSM state
//                encoding, default timeout length and a grant decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Default number of idle cycles before a granted requester is dropped
    localparam int C_TIMEOUT_CYCLES = 255;

    // One-hot grant vector for a given state, bit n = requester n
    function automatic logic [1:0] gnt_of(input state_t s);
        gnt_of = {(s == GNT1), (s == GNT0)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Two-requester round-robin arbiter in front of a UART TX
//                FIFO. A grant is held for a whole burst (until the byte
//                flagged "last" is accepted). At most one byte is loaded
//                every two cycles so a one-cycle-late full flag is safe.
//                Optional grant timeout enabled by UART_TX_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       last0,
    input  logic       last1,
    output logic       ack0,
    output logic       ack1,
    input  logic       full,
    output logic       ld_tx_fifo,
    output logic [7:0] fifo_data_in,
    output logic [1:0] gnt,
    output logic       timeout
);

    // A zero-length timeout would revoke every grant on the cycle it starts
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_served;
    logic       w_last_served_nxt;
    logic [1:0] r_gnt;
    logic       r_ld;
    logic [7:0] r_data;
    logic       w_ack0;
    logic       w_ack1;
    logic       w_ack_any;
    logic       w_expire;

    // Accept only from the granted requester, never while the FIFO is full,
    // never on the cycle right after a load, and never during reset.
    assign w_ack0    = (r_state == GNT0) && req0 && !full && !r_ld && !rst;
    assign w_ack1    = (r_state == GNT1) && req1 && !full && !r_ld && !rst;
    assign w_ack_any = w_ack0 || w_ack1;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_granted_req;
    logic             r_timeout;

    // Request line of whichever requester currently holds the grant
    assign w_granted_req = ((r_state == GNT0) && req0) || ((r_state == GNT1) && req1);

    // Counter has reached the limit and no byte is being accepted this cycle
    assign w_expire = (r_state != IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES)) && !w_ack_any;

    // Count granted cycles with the owner's request low; restart on any
    // accepted byte or grant change. Stalls on full with request high hold.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == IDLE) || (w_state_nxt != r_state) || w_ack_any) begin
            r_cnt <= '0;
        end else if (!w_granted_req) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // One-cycle pulse registered on the edge that revokes the grant
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Next-state and round-robin bookkeeping
    always_comb begin
        w_state_nxt       = r_state;
        w_last_served_nxt = r_last_served;
        case (r_state)
            IDLE: begin
                if (req0 && req1) begin
                    // Tie: the requester that did not finish last wins
                    w_state_nxt = r_last_served ? GNT0 : GNT1;
                end else if (req0) begin
                    w_state_nxt = GNT0;
                end else if (req1) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                if ((w_ack0 && last0) || w_expire) begin
                    w_state_nxt       = IDLE;
                    w_last_served_nxt = 1'b0;
                end
            end
            GNT1: begin
                if ((w_ack1 && last1) || w_expire) begin
                    w_state_nxt       = IDLE;
                    w_last_served_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, round-robin pointer and registered grant
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_served <= 1'b1;
            r_gnt         <= 2'b00;
        end else begin
            r_state       <= w_state_nxt;
            r_last_served <= w_last_served_nxt;
            r_gnt         <= gnt_of(w_state_nxt);
        end
    end

    // FIFO load strobe and captured byte; the byte holds between loads
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_ld   <= 1'b0;
            r_data <= 8'h00;
        end else begin
            r_ld <= w_ack_any;
            if (w_ack0) begin
                r_data <= data0;
            end else if (w_ack1) begin
                r_data <= data1;
            end
        end
    end

    assign ack0         = w_ack0;
    assign ack1         = w_ack1;
    assign ld_tx_fifo   = r_ld;
    assign fifo_data_in = r_data;
    assign gnt          = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter. Requesters are
//                modelled as byte queues that advance on ack; expected byte
//                streams and timing come from burst-level rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       last0, last1;
    logic       ack0, ack1;
    logic       full;
    logic       ld_tx_fifo;
    logic [7:0] fifo_data_in;
    logic [1:0] gnt;
    logic       timeout;

    always #10 sys_clk = ~sys_clk;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .data0       (data0),
        .data1       (data1),
        .last0       (last0),
        .last1       (last1),
        .ack0        (ack0),
        .ack1        (ack1),
        .full        (full),
        .ld_tx_fifo  (ld_tx_fifo),
        .fifo_data_in(fifo_data_in),
        .gnt         (gnt),
        .timeout     (timeout)
    );

    int total  = 0;
    int passed = 0;

    // Requester byte queues: bit 8 = last flag, bits 7:0 = data
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       en0 = 1'b1;
    logic       en1 = 1'b1;

    // Per-cycle observation log (one entry per negedge sample)
    logic [1:0] lg_gnt[$];
    logic       lg_ld[$];
    logic       lg_to[$];
    logic       lg_a0[$];
    logic       lg_a1[$];
    logic [7:0] lg_data[$];
    logic [7:0] loads[$];
    int         load_idx[$];
    logic       prev_ld = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_a[4] = '{8'h55, 8'hF0, 8'h0F, 8'hAA};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive();
        req0  = en0 && (q0.size() != 0);
        data0 = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
        last0 = (q0.size() != 0) ? q0[0][8]   : 1'b0;
        req1  = en1 && (q1.size() != 0);
        data1 = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
        last1 = (q1.size() != 0) ? q1[0][8]   : 1'b0;
    endtask

    task automatic clear_logs();
        lg_gnt.delete(); lg_ld.delete(); lg_to.delete();
        lg_a0.delete(); lg_a1.delete(); lg_data.delete();
        loads.delete(); load_idx.delete();
    endtask

    // One clock: sample at negedge, then advance requesters after posedge
    task automatic step();
        logic a0, a1;
        @(negedge sys_clk);
        a0 = ack0;
        a1 = ack1;
        lg_gnt.push_back(gnt);
        lg_ld.push_back(ld_tx_fifo);
        lg_to.push_back(timeout);
        lg_a0.push_back(a0);
        lg_a1.push_back(a1);
        lg_data.push_back(fifo_data_in);
        if (ld_tx_fifo) begin
            loads.push_back(fifo_data_in);
            load_idx.push_back(lg_ld.size() - 1);
        end
        chk("gnt_onehot", 32'(gnt == 2'b11), 32'd0);
        chk("ld_spacing", 32'(ld_tx_fifo & prev_ld), 32'd0);
        chk("ack_without_gnt", 32'((a0 & ~gnt[0]) | (a1 & ~gnt[1])), 32'd0);
        chk("ack_while_full", 32'((a0 | a1) & full), 32'd0);
        prev_ld = ld_tx_fifo;
        @(posedge sys_clk);
        #1;
        if (a0 && q0.size() != 0) void'(q0.pop_front());
        if (a1 && q1.size() != 0) void'(q1.pop_front());
        drive();
    endtask

    task automatic run_loads(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (loads.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(loads.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        en0 = 1'b1; en1 = 1'b1; full = 1'b0;
        rst = 1'b1;
        drive();
        repeat (2) @(posedge sys_clk);
        #1;
        rst = 1'b0;
        prev_ld = 1'b0;
        clear_logs();
    endtask

    task automatic gen_burst(input int who);
        int len;
        logic [7:0] b;
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            if (who == 0) q0.push_back({(i == len - 1), b});
            else          q1.push_back({(i == len - 1), b});
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t0, bad, st, pulses;

        // ---------------- reset state (requests pending during reset) ----
        rst = 1'b1; full = 1'b0;
        q0.push_back(9'h1EE); q1.push_back(9'h1DD);
        drive();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ld", 32'(ld_tx_fifo), 32'd0);
        chk("rst_data", 32'(fifo_data_in), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_ack", 32'({ack1, ack0}), 32'd0);

        // ---------------- single burst ------------------------------------
        do_reset();
        q0.push_back(9'h055); q0.push_back(9'h0F0);
        q0.push_back(9'h00F); q0.push_back(9'h1AA);
        drive();
        run_loads(4, 40, "A_budget");
        step();
        for (int i = 0; i < 4; i++) chk("A_byte", 32'(loads[i]), 32'(exp_a[i]));
        chk("A_latency", 32'(load_idx[0]), 32'd2);
        for (int i = 0; i < 3; i++) chk("A_spacing", 32'(load_idx[i+1] - load_idx[i]), 32'd2);
        bad = 0;
        for (int k = 1; k < load_idx[3]; k++) if (lg_gnt[k] !== 2'b01) bad++;
        chk("A_gnt_held", 32'(bad), 32'd0);
        chk("A_gnt_release", 32'(lg_gnt[load_idx[3]]), 32'd0);

        // ---------------- tie after reset ---------------------------------
        do_reset();
        q0.push_back(9'h0A1); q0.push_back(9'h1A2); q1.push_back(9'h1B1);
        drive();
        run_loads(3, 40, "B_budget");
        step();
        chk("B_first_gnt", 32'(lg_gnt[1]), 32'd1);
        chk("B_b0", 32'(loads[0]), 32'hA1);
        chk("B_b1", 32'(loads[1]), 32'hA2);
        chk("B_b2", 32'(loads[2]), 32'hB1);
        chk("B_idle_gap", 32'(lg_gnt[load_idx[1]]), 32'd0);
        chk("B_second_gnt", 32'(lg_gnt[load_idx[1] + 1]), 32'd2);

        // ---------------- backpressure ------------------------------------
        do_reset();
        q0.push_back(9'h011); q0.push_back(9'h022);
        q0.push_back(9'h033); q0.push_back(9'h144); q1.push_back(9'h1C1);
        drive();
        run_loads(1, 20, "C_budget1");
        full = 1'b1;
        st = lg_gnt.size();
        repeat (10) step();
        full = 1'b0;
        bad = 0;
        for (int k = st; k < st + 10; k++) if (lg_a0[k] || lg_ld[k] || lg_gnt[k] !== 2'b01) bad++;
        chk("C_stall", 32'(bad), 32'd0);
        run_loads(5, 60, "C_budget2");
        chk("C_resume_time", 32'(load_idx[1]), 32'(st + 11));
        chk("C_b1", 32'(loads[1]), 32'h22);
        chk("C_b3", 32'(loads[3]), 32'h44);
        chk("C_other", 32'(loads[4]), 32'hC1);

        // ---------------- reset mid-burst ---------------------------------
        do_reset();
        q0.push_back(9'h1D0);
        drive();
        run_loads(1, 20, "D_budget0");
        repeat (2) step();
        clear_logs();
        q0.push_back(9'h061); q0.push_back(9'h062);
        q0.push_back(9'h063); q0.push_back(9'h164);
        drive();
        run_loads(2, 30, "D_budget1");
        rst = 1'b1;
        drive();
        step();
        chk("D_ack_in_rst", 32'(lg_a0[lg_a0.size() - 1]), 32'd0);
        rst = 1'b0;
        prev_ld = 1'b0;
        q0.delete();
        q0.push_back(9'h1E0); q1.push_back(9'h1E1);
        drive();
        step();
        chk("D_gnt_after_rst", 32'(lg_gnt[lg_gnt.size() - 1]), 32'd0);
        chk("D_ld_after_rst", 32'(lg_ld[lg_ld.size() - 1]), 32'd0);
        chk("D_data_after_rst", 32'(lg_data[lg_data.size() - 1]), 32'd0);
        step();
        chk("D_tie_winner", 32'(lg_gnt[lg_gnt.size() - 1]), 32'd1);
        run_loads(4, 40, "D_budget2");
        chk("D_b2", 32'(loads[2]), 32'hE0);
        chk("D_b3", 32'(loads[3]), 32'hE1);

        // ---------------- requester drops mid-burst -----------------------
        do_reset();
        q0.push_back(9'h071); q0.push_back(9'h072);
        q0.push_back(9'h073); q0.push_back(9'h174); q1.push_back(9'h1F1);
        drive();
        run_loads(2, 30, "E_budget1");
        en0 = 1'b0;
        drive();
        t0 = lg_gnt.size();
`ifdef UART_TX_ARB_TIMEOUT_EN
        repeat (7) step();
        pulses = 0;
        for (int k = t0; k < t0 + 7; k++) if (lg_to[k]) pulses++;
        chk("E_to_pulses", 32'(pulses), 32'd1);
        chk("E_to_time", 32'(lg_to[t0 + 5]), 32'd1);
        chk("E_gnt_before", 32'(lg_gnt[t0 + 4]), 32'd1);
        chk("E_gnt_revoked", 32'(lg_gnt[t0 + 5]), 32'd0);
        chk("E_gnt_other", 32'(lg_gnt[t0 + 6]), 32'd2);
        run_loads(3, 30, "E_budget2");
        en0 = 1'b1;
        drive();
        run_loads(5, 40, "E_budget3");
        chk("E_b2", 32'(loads[2]), 32'hF1);
        chk("E_b3", 32'(loads[3]), 32'h73);
        chk("E_b4", 32'(loads[4]), 32'h74);
`else
        repeat (20) step();
        bad = 0;
        pulses = 0;
        for (int k = t0; k < t0 + 20; k++) begin
            if (lg_gnt[k] !== 2'b01) bad++;
            if (lg_to[k] !== 1'b0) pulses++;
        end
        chk("E_gnt_held", 32'(bad), 32'd0);
        chk("E_no_timeout", 32'(pulses), 32'd0);
        chk("E_no_loads", 32'(loads.size()), 32'd2);
        en0 = 1'b1;
        drive();
        run_loads(5, 40, "E_budget3");
        chk("E_b2", 32'(loads[2]), 32'h73);
        chk("E_b3", 32'(loads[3]), 32'h74);
        chk("E_b4", 32'(loads[4]), 32'hF1);
`endif

        // ---------------- randomized alternating bursts with full noise ---
        for (int r = 0; r < 3; r++) begin
            int k;
            do_reset();
            exp_q.delete();
            // Both requesters stay busy, so grants alternate burst by burst
            for (int b = 0; b < 3; b++) begin
                gen_burst(0);
                gen_burst(1);
            end
            drive();
            k = 0;
            while (loads.size() < exp_q.size() && k < 600) begin
                full = ($urandom_range(0, 3) == 0);
                step();
                k++;
            end
            full = 1'b0;
            chk("R_budget", 32'(loads.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++) chk("R_byte", 32'(loads[i]), 32'(exp_q[i]));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
